// File: rtl/quad_encoder_gen_pkg.sv
// Shared definitions for the quadrature generator and receiver: FSM encoding
// and the position-to-(A,B) phase lookup.
package quad_encoder_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Position mod 4 mapped onto the corotation sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] quad_phase(input logic [1:0] idx);
        logic [1:0] ab;
        case (idx)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            default: ab = 2'b01;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/quad_encoder_gen_step_timer.sv
// Reloading down-counter that pulses expire_o every period_i enabled clocks.
module step_timer #(
    parameter int PER_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [PER_W-1:0] period_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [PER_W-1:0] per_q;
    logic [PER_W-1:0] cnt_q;

    assign expire_o = en_i && (cnt_q == PER_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            per_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            per_q <= period_i;
            cnt_q <= period_i;
        end else if (en_i) begin
            if (cnt_q == PER_W'(1)) begin
                cnt_q <= per_q;
            end else begin
                cnt_q <= cnt_q - PER_W'(1);
            end
        end
    end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder generator: emits a fixed number of A/B edges at a set
// rate in either direction, tracking position and the once-per-rev index.
module quad_encoder_gen
    import quad_encoder_gen_pkg::*;
#(
    parameter int COUNTS_PER_REV = 4000,
    parameter int PER_W          = 16,
    parameter int STEP_W         = 16
) (
    input  logic                              CLOCK_50M,
    input  logic                              RST,
    input  logic                              iStart,
    input  logic                              iDir,
    input  logic [STEP_W-1:0]                 iSteps,
    input  logic [PER_W-1:0]                  iStepPeriod,
    input  logic                              iAbort,
    output logic                              oSignalA,
    output logic                              oSignalB,
    output logic                              oSignalZ,
    output logic [$clog2(COUNTS_PER_REV)-1:0] oPosition,
    output logic                              oBusy,
    output logic                              oDone
);

    localparam int POS_W = $clog2(COUNTS_PER_REV);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(COUNTS_PER_REV - 1);

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              a_q, b_q, z_q, busy_q, done_q;
    logic              load, expire, timer_en;
    logic [PER_W-1:0]  period_eff;

    assign period_eff = (iStepPeriod == '0) ? PER_W'(1) : iStepPeriod;
    assign timer_en   = (state_q == ST_RUN);

    step_timer #(.PER_W(PER_W)) u_step_timer (
        .clk_i    (CLOCK_50M),
        .rst_i    (RST),
        .load_i   (load),
        .period_i (period_eff),
        .en_i     (timer_en),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    if (iSteps != '0) begin
                        state_d = ST_RUN;
                        dir_d   = iDir;
                        rem_d   = iSteps;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_RUN: begin
                // Abort outranks a coinciding expiry so no edge slips out.
                if (iAbort) begin
                    state_d = ST_FINISH;
                end else if (expire) begin
                    rem_d = rem_q - STEP_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        state_d = ST_FINISH;
                    end
                    if (dir_q) begin
                        pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
                    end else begin
                        pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they align with state_q.
    always_ff @(posedge CLOCK_50M or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            pos_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            z_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            rem_q      <= rem_d;
            pos_q      <= pos_d;
            {a_q, b_q} <= quad_phase(pos_d[1:0]);
            z_q        <= (pos_d == '0);
            busy_q     <= (state_d == ST_RUN);
            done_q     <= (state_d == ST_FINISH);
        end
    end

    assign oSignalA  = a_q;
    assign oSignalB  = b_q;
    assign oSignalZ  = z_q;
    assign oPosition = pos_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: two instances (4000 and 8 counts/rev) share
// stimulus and are compared each cycle against a timing/position model.
module tb_quad_encoder_gen;

    localparam int C0 = 4000;
    localparam int C1 = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic        abort_s = 1'b0;
    logic [15:0] steps = '0;
    logic [15:0] per = '0;

    logic        a0, b0, z0, busy0, done0;
    logic [11:0] pos0;
    logic        a1, b1, z1, busy1, done1;
    logic [2:0]  pos1;

    logic [1:0]  ab_o   [2];
    logic        z_o    [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic [31:0] pos_w  [2];

    assign ab_o[0]   = {a0, b0};
    assign ab_o[1]   = {a1, b1};
    assign z_o[0]    = z0;
    assign z_o[1]    = z1;
    assign busy_o[0] = busy0;
    assign busy_o[1] = busy1;
    assign done_o[0] = done0;
    assign done_o[1] = done1;
    assign pos_w[0]  = 32'(pos0);
    assign pos_w[1]  = 32'(pos1);

    int checks = 0;
    int failures = 0;
    int mpos [2] = '{0, 0};
    int cpr  [2] = '{C0, C1};
    logic [1:0] ph [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always #10 clk = ~clk;

    quad_encoder_gen #(.COUNTS_PER_REV(C0), .PER_W(16), .STEP_W(16)) u_dut0 (
        .CLOCK_50M(clk), .RST(rst), .iStart(start), .iDir(dir), .iSteps(steps),
        .iStepPeriod(per), .iAbort(abort_s), .oSignalA(a0), .oSignalB(b0),
        .oSignalZ(z0), .oPosition(pos0), .oBusy(busy0), .oDone(done0)
    );

    quad_encoder_gen #(.COUNTS_PER_REV(C1), .PER_W(16), .STEP_W(16)) u_dut1 (
        .CLOCK_50M(clk), .RST(rst), .iStart(start), .iDir(dir), .iSteps(steps),
        .iStepPeriod(per), .iAbort(abort_s), .oSignalA(a1), .oSignalB(b1),
        .oSignalZ(z1), .oPosition(pos1), .oBusy(busy1), .oDone(done1)
    );

    // Runs one move and checks every cycle. a = expiry index at which abort is
    // raised (0 = none); ign = cycle at which a stray iStart is pulsed (-1 = none).
    task automatic run_move(input bit d, input int n, input int p, input int a, input int ign);
        int pe, lim, end_t, e, ep;
        int p0 [2];
        int nchg [2];
        logic [1:0] prev [2];
        pe    = (p == 0) ? 1 : p;
        lim   = (a > 0) ? a - 1 : n;
        end_t = (a > 0) ? a * pe : n * pe;
        for (int i = 0; i < 2; i++) begin
            p0[i]   = mpos[i];
            nchg[i] = 0;
            prev[i] = ab_o[i];
        end
        @(negedge clk);
        start = 1'b1; dir = d; steps = 16'(n); per = 16'(p); abort_s = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t <= end_t + 1; t++) begin
            e = t / pe;
            if (e > lim) e = lim;
            for (int i = 0; i < 2; i++) begin
                ep = d ? (p0[i] + e) % cpr[i] : (((p0[i] - e) % cpr[i]) + cpr[i]) % cpr[i];
                checks++;
                if ({ab_o[i], z_o[i], busy_o[i], done_o[i]} !== {ph[ep % 4], (ep == 0), (t < end_t), (t == end_t)}
                    || pos_w[i] !== 32'(ep)) begin
                    failures++;
                    $display("FAIL move inst%0d t=%0d got ab=%b z=%b busy=%b done=%b pos=%0d want ab=%b z=%b busy=%b done=%b pos=%0d",
                             i, t, ab_o[i], z_o[i], busy_o[i], done_o[i], pos_w[i],
                             ph[ep % 4], (ep == 0), (t < end_t), (t == end_t), ep);
                end
                if (ab_o[i] !== prev[i]) begin
                    nchg[i]++;
                    checks++;
                    if ((ab_o[i] ^ prev[i]) == 2'b11) begin
                        failures++;
                        $display("FAIL single_bit inst%0d t=%0d got %b->%b required one bit change",
                                 i, t, prev[i], ab_o[i]);
                    end
                end
                prev[i] = ab_o[i];
            end
            start = (t == ign);
            if (t == ign) begin
                steps = 16'($urandom_range(1, 20));
                dir   = ~d;
                per   = 16'($urandom_range(1, 3));
            end
            abort_s = (a > 0) && (t == a * pe - 1);
            @(negedge clk);
        end
        start = 1'b0;
        abort_s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (nchg[i] != lim) begin
                failures++;
                $display("FAIL edge_count inst%0d got %0d required %0d", i, nchg[i], lim);
            end
            mpos[i] = d ? (p0[i] + lim) % cpr[i] : (((p0[i] - lim) % cpr[i]) + cpr[i]) % cpr[i];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort_s = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({ab_o[i], z_o[i], busy_o[i], done_o[i]} !== 5'b00100 || pos_w[i] !== 32'd0) begin
                    failures++;
                    $display("FAIL reset inst%0d phase%0d got ab=%b z=%b busy=%b done=%b pos=%0d required ab=00 z=1 busy=0 done=0 pos=0",
                             i, k, ab_o[i], z_o[i], busy_o[i], done_o[i], pos_w[i]);
                end
            end
            rst = 1'b0;
            @(negedge clk);
        end
        mpos[0] = 0;
        mpos[1] = 0;
    endtask

    task automatic test_forward();
        run_move(1'b1, 8, 5, 0, -1);
        checks++;
        if (pos0 !== 12'd8) begin
            failures++;
            $display("FAIL forward_pos got %0d required 8", pos0);
        end
    endtask

    task automatic test_reverse();
        test_reset();
        run_move(1'b0, 2, $urandom_range(1, 4), 0, -1);
        checks++;
        if (pos0 !== 12'(C0 - 2)) begin
            failures++;
            $display("FAIL reverse_pos got %0d required %0d", pos0, C0 - 2);
        end
    endtask

    task automatic test_wrap();
        test_reset();
        run_move(1'b1, 10, 1, 0, -1);
        checks++;
        if (pos1 !== 3'd2) begin
            failures++;
            $display("FAIL wrap_pos got %0d required 2", pos1);
        end
    endtask

    task automatic test_abort();
        run_move(1'b1, 6, 3, 3, -1);
    endtask

    task automatic test_zero_and_ignore();
        run_move(1'b0, 0, 4, 0, -1);
        run_move(1'b1, 5, 2, 0, 3);
    endtask

    task automatic test_random();
        int n, p, a, ign, et;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 12);
            p = $urandom_range(0, 5);
            a = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            et = ((a > 0) ? a : n) * ((p == 0) ? 1 : p);
            ign = (et > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, et - 1) : -1;
            run_move(1'($urandom_range(0, 1)), n, p, a, ign);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; dir = 1'b1; steps = 16'd10; per = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy got %b required 1", busy0);
        end
        #5 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({ab_o[i], z_o[i], busy_o[i], done_o[i]} !== 5'b00100 || pos_w[i] !== 32'd0) begin
                    failures++;
                    $display("FAIL mid_reset inst%0d step%0d got ab=%b z=%b busy=%b done=%b pos=%0d required ab=00 z=1 busy=0 done=0 pos=0",
                             i, k, ab_o[i], z_o[i], busy_o[i], done_o[i], pos_w[i]);
                end
            end
            @(negedge clk);
            if (k == 1) rst = 1'b0;
        end
        mpos[0] = 0;
        mpos[1] = 0;
        run_move(1'b1, 3, 2, 0, -1);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_wrap();
        test_abort();
        test_zero_and_ignore();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
